// File: rtl/conv_window_ctrl_pkg.sv
// Shared constants and FSM state type for the convolution line-buffer sequencer.
// Module parameters default to these so a full-size build needs no overrides.
package conv_pkg;
  localparam int IMG_W = 220;
  localparam int IMG_H = 220;
  localparam int K     = 3;
  localparam int DW    = 16;
  localparam int D     = IMG_W - K;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } ctrl_state_t;
endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel/window handshake bundle between the pixel source, the controller and the MAC array.
// "slave" is the controller side; "master" is the source/sink environment side.
interface conv_window_ctrl_if #(
  parameter int CW = 8,
  parameter int RW = 8
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          shift_en;
  logic          win_valid;
  logic          out_ready;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          busy;
  logic          done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, shift_en, win_valid, win_col, win_row, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, shift_en, win_valid, win_col, win_row, busy, done
  );
endinterface

// File: rtl/conv_window_ctrl_raster_counter.sv
// Raster col/row position of the next pixel to be accepted.
// Row saturates on the final pixel so it never wraps inside a frame.
module raster_counter #(
  parameter int IMG_W = 220,
  parameter int IMG_H = 220,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_wrap,
  output logic          o_last
);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_wrap = (r_col == CW'(IMG_W - 1));
  assign o_last = o_wrap && (r_row == RW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_inc) begin
      if (o_wrap) begin
        r_col <= '0;
        if (!o_last) r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// Convolution window sequencer: accepts raster pixels, gates line-buffer shifts and
// presents each fully valid KxK window position to the MAC array with back-pressure.
module conv_window_ctrl #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H,
  parameter int K     = conv_pkg::K,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  conv_window_ctrl_if.slave  bus
);
  import conv_pkg::*;

  ctrl_state_t   r_state, w_state_nxt;
  logic          w_clr, w_done_nxt;
  logic          w_in_ready, w_acc, w_win_form;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_wrap, w_last;

  logic          r_win_valid;
  logic [CW-1:0] r_win_col;
  logic [RW-1:0] r_win_row;
  logic          r_done;

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_acc),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_wrap (w_wrap),
    .o_last (w_last)
  );

  // A held window blocks new pixels unless it is being consumed this cycle.
  assign w_in_ready = (r_state == S_STREAM) && (!r_win_valid || bus.out_ready);
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_win_form = w_acc && (w_col >= CW'(K - 1)) && (w_row >= RW'(K - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_STREAM;
          w_clr       = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_acc && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_win_valid || bus.out_ready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Window register: a new window may replace a consumed one in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      r_win_col   <= '0;
      r_win_row   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_win_form) begin
        r_win_valid <= 1'b1;
        r_win_col   <= w_col - CW'(K - 1);
        r_win_row   <= w_row - RW'(K - 1);
      end else if (bus.out_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.shift_en  = w_acc;
  assign bus.win_valid = r_win_valid;
  assign bus.win_col   = r_win_col;
  assign bus.win_row   = r_win_row;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

  logic w_unused;
  assign w_unused = w_wrap;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench: stimulus pushes expected windows, negedge monitors pop and compare.
module tb_conv_window_ctrl;
  localparam int SW = 5, SH = 4, SK = 3;
  localparam int SCW = $clog2(SW), SRW = $clog2(SH);
  localparam int BW = 220, BH = 220, BK = 3;
  localparam int BCW = $clog2(BW), BRW = $clog2(BH);

  typedef struct { int c; int r; } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  conv_window_ctrl_if #(.CW(SCW), .RW(SRW)) s_if ();
  conv_window_ctrl_if #(.CW(BCW), .RW(BRW)) b_if ();

  conv_window_ctrl #(.IMG_W(SW), .IMG_H(SH), .K(SK), .CW(SCW), .RW(SRW)) u_small (
    .clk (clk), .rst (rst), .bus (s_if.slave)
  );
  conv_window_ctrl #(.IMG_W(BW), .IMG_H(BH), .K(BK), .CW(BCW), .RW(BRW)) u_big (
    .clk (clk), .rst (rst), .bus (b_if.slave)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- small-frame scoreboard ----------------
  win_t sq[$];
  int s_acc, s_win_cnt, s_done_cnt, s_first_acc, s_done_cyc, s_last_acc_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (s_if.win_valid) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_win_unexpected: got (%0d,%0d) expected none", s_if.win_col, s_if.win_row);
        end else begin
          chk("s_win_col", s_if.win_col, sq[0].c);
          chk("s_win_row", s_if.win_row, sq[0].r);
        end
        if (s_first_acc < 0) s_first_acc = s_acc;
        if (!s_if.out_ready) chk("s_backpressure_in_ready", s_if.in_ready, 0);
        else begin
          if (sq.size() > 0) void'(sq.pop_front());
          s_win_cnt++;
        end
      end
      if (s_if.shift_en) begin s_acc++; s_last_acc_cyc = cyc; end
      if (s_if.done) begin s_done_cnt++; s_done_cyc = cyc; end
    end
  end

  // ---------------- full-frame scoreboard ----------------
  win_t bq[$];
  int b_acc, b_win_cnt, b_done_cnt, b_last_c, b_last_r;

  always @(negedge clk) begin
    if (!rst) begin
      if (b_if.win_valid && b_if.out_ready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_win_unexpected: got (%0d,%0d) expected none", b_if.win_col, b_if.win_row);
        end else begin
          chk("b_win_col", b_if.win_col, bq[0].c);
          chk("b_win_row", b_if.win_row, bq[0].r);
          void'(bq.pop_front());
        end
        b_win_cnt++;
        b_last_c = b_if.win_col;
        b_last_r = b_if.win_row;
      end
      if (b_if.shift_en) b_acc++;
      if (b_if.done) b_done_cnt++;
    end
  end

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"},  s_if.in_ready, 0);
    chk({tag, "_shift_en"},  s_if.shift_en, 0);
    chk({tag, "_win_valid"}, s_if.win_valid, 0);
    chk({tag, "_win_col"},   s_if.win_col, 0);
    chk({tag, "_win_row"},   s_if.win_row, 0);
    chk({tag, "_busy"},      s_if.busy, 0);
    chk({tag, "_done"},      s_if.done, 0);
  endtask

  task automatic run_small(input bit gaps, input bit stall, input bit smid,
                           input int abort_at, input string tag);
    int sent = 0, budget = 0, w = 0;
    int target = (abort_at > 0) ? abort_at : SW * SH;
    int stall_left = stall ? 4 : 0;
    s_acc = 0; s_win_cnt = 0; s_done_cnt = 0; s_first_acc = -1;
    s_done_cyc = 0; s_last_acc_cyc = 0;
    sq.delete();
    if (abort_at == 0)
      for (int r = 0; r <= SH - SK; r++)
        for (int c = 0; c <= SW - SK; c++) sq.push_back('{c: c, r: r});
    s_if.start = 1'b1;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    chk({tag, "_busy_after_start"}, s_if.busy, 1);
    while (sent < target && budget < 400) begin
      s_if.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.start    = smid && (sent == 7);
      if (stall_left > 0 && s_if.win_valid) begin
        s_if.out_ready = 1'b0;
        stall_left--;
      end else s_if.out_ready = 1'b1;
      @(negedge clk);
      if (s_if.shift_en) sent++;
      @(posedge clk); #1;
      budget++;
    end
    s_if.in_valid = 1'b0; s_if.start = 1'b0; s_if.out_ready = 1'b1;
    chk({tag, "_sent_in_budget"}, sent, target);
    if (abort_at > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk({tag, "_no_window"}, s_win_cnt, 0);
      check_idle({tag, "_reset"});
      return;
    end
    while (s_done_cnt == 0 && w < 50) begin @(posedge clk); #1; w++; end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_accepts"},      s_acc, SW * SH);
    chk({tag, "_windows"},      s_win_cnt, (SW - SK + 1) * (SH - SK + 1));
    chk({tag, "_done_pulses"},  s_done_cnt, 1);
    chk({tag, "_done_latency"}, s_done_cyc - s_last_acc_cyc, 2);
    chk({tag, "_first_win_after_acc"}, s_first_acc, 13);
    chk({tag, "_queue_left"},   sq.size(), 0);
    chk({tag, "_busy_end"},     s_if.busy, 0);
  endtask

  task automatic run_big();
    int budget = 0;
    b_acc = 0; b_win_cnt = 0; b_done_cnt = 0; b_last_c = -1; b_last_r = -1;
    bq.delete();
    for (int r = 0; r <= BH - BK; r++)
      for (int c = 0; c <= BW - BK; c++) bq.push_back('{c: c, r: r});
    b_if.start = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    b_if.in_valid = 1'b1;
    while (b_done_cnt == 0 && budget < 50000) begin @(posedge clk); #1; budget++; end
    b_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("big_done_seen",  b_done_cnt, 1);
    chk("big_accepts",    b_acc, BW * BH);
    chk("big_windows",    b_win_cnt, 47524);
    chk("big_last_col",   b_last_c, 217);
    chk("big_last_row",   b_last_r, 217);
    chk("big_queue_left", bq.size(), 0);
  endtask

  initial begin
    s_if.start = 1'b0; s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
    b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
    s_acc = 0; s_win_cnt = 0; s_done_cnt = 0; s_first_acc = -1;
    b_acc = 0; b_win_cnt = 0; b_done_cnt = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // in_valid in IDLE must not be accepted
    @(posedge clk); #1;
    s_if.in_valid = 1'b1;
    repeat (3) check_idle("idle_valid");
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    chk("idle_accepts", s_acc, 0);

    run_small(1'b0, 1'b0, 1'b0, 0, "cont");
    run_small(1'b0, 1'b1, 1'b0, 0, "stall");
    run_small(1'b1, 1'b0, 1'b0, 0, "gaps");
    run_small(1'b0, 1'b0, 1'b1, 0, "start_mid");
    run_small(1'b0, 1'b0, 1'b0, 11, "abort");
    run_small(1'b0, 1'b0, 1'b0, 0, "post_reset");
    run_big();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
